parity_codec: RTL and testbench

Parametrised multi-lane parity generator/checker with a valid/ready stream interface on both sides.
- Generate mode: appends one parity bit per lane.
- Check mode: recomputes parity on received lanes, flags per-lane errors and accumulates a saturating error count.
- A 2-entry output buffer keeps full throughput under backpressure with a registered in_ready.
- Sits between a byte/word source and a serial link (UART/SPI framing) or at the receive side of that link.

---
 rtl/parity_codec.sv | 114 +++++++++++
 tb/tb_parity_codec.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_codec.sv
// Multi-lane parity generator/checker with valid/ready streams on both sides.
// Beats are parity-processed on acceptance and queued in a 2-entry output buffer.
module parity_codec #(
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 4,
  parameter int PARITY_TYPE   = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*(DATA_WIDTH+1)-1:0]   in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*(DATA_WIDTH+1)-1:0]   out_data,
  output logic [LANES-1:0]                  out_err,
  output logic [ERR_CNT_WIDTH-1:0]          err_cnt,
  input  logic                              err_cnt_clr
);

  localparam int   LW  = DATA_WIDTH + 1;
  localparam int   BW  = LANES * LW;
  localparam int   PW  = $clog2(LANES + 1);
  localparam int   SW  = ERR_CNT_WIDTH + PW;
  localparam logic ODD = (PARITY_TYPE != 0);

  logic [BW-1:0]         proc_data;
  logic [LANES-1:0]      proc_err;
  logic [PW-1:0]         err_pop;
  logic [DATA_WIDTH-1:0] lane_d;
  logic                  lane_p;

  logic [BW-1:0]         buf_data [2];
  logic [LANES-1:0]      buf_err  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [SW-1:0]         err_sum;

  always_comb begin
    proc_data = '0;
    proc_err  = '0;
    err_pop   = '0;
    lane_d    = '0;
    lane_p    = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_d = in_data[i*LW +: DATA_WIDTH];
      lane_p = (^lane_d) ^ ODD;
      if (mode) begin
        proc_data[i*LW +: LW] = in_data[i*LW +: LW];
        proc_err[i]           = (in_data[i*LW + DATA_WIDTH] != lane_p);
      end else begin
        proc_data[i*LW +: LW] = {lane_p, lane_d};
      end
      err_pop = err_pop + PW'(proc_err[i]);
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = buf_data[rd_ptr];
  assign out_err  = buf_err[rd_ptr];
  assign err_sum  = SW'(err_cnt) + SW'(err_pop);

  always_comb begin
    count_nxt = count;
    case ({in_xfer, out_xfer})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // in_ready/out_valid are registered from the next occupancy so they never
  // depend combinationally on the downstream handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned e = 0; e < 2; e++) begin
        buf_data[e] <= '0;
        buf_err[e]  <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (in_xfer) begin
        buf_data[wr_ptr] <= proc_data;
        buf_err[wr_ptr]  <= proc_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      count     <= count_nxt;
      in_ready  <= (count_nxt != 2'd2);
      out_valid <= (count_nxt != 2'd0);
      if (err_cnt_clr) begin
        err_cnt <= '0;
      end else if (in_xfer) begin
        if (|err_sum[SW-1:ERR_CNT_WIDTH]) err_cnt <= '1;
        else                              err_cnt <= err_sum[ERR_CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_parity_codec.sv
// Self-checking bench for parity_codec: directed scenarios plus a randomized
// stream compared against a queue-based behavioural model.
module tb_parity_codec;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int LW = W + 1;
  localparam int BW = L * LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic          a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_cnt_clr;
  logic [BW-1:0] a_in_data, a_out_data;
  logic [L-1:0]  a_out_err;
  logic [15:0]   a_err_cnt;

  logic          b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_cnt_clr;
  logic [BW-1:0] b_in_data, b_out_data;
  logic [L-1:0]  b_out_err;
  logic [2:0]    b_err_cnt;

  int checks = 0;
  int errors = 0;

  parity_codec #(.DATA_WIDTH(W), .LANES(L), .PARITY_TYPE(1), .ERR_CNT_WIDTH(16)) u_a (
    .clk(clk), .rstn(rstn), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err), .err_cnt(a_err_cnt), .err_cnt_clr(a_err_cnt_clr)
  );

  parity_codec #(.DATA_WIDTH(W), .LANES(L), .PARITY_TYPE(0), .ERR_CNT_WIDTH(3)) u_b (
    .clk(clk), .rstn(rstn), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err), .err_cnt(b_err_cnt), .err_cnt_clr(b_err_cnt_clr)
  );

  // Reference: parity bit chosen so the lane's total count of ones is odd/even.
  function automatic logic [BW+L-1:0] model(input logic [BW-1:0] din, input logic m, input bit odd);
    logic [BW-1:0] dout;
    logic [L-1:0]  err;
    logic [W-1:0]  d;
    logic          p;
    int            ones;
    dout = '0;
    err  = '0;
    for (int i = 0; i < L; i++) begin
      d    = din[i*LW +: W];
      ones = $countones(d);
      p    = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (m) begin
        dout[i*LW +: LW] = din[i*LW +: LW];
        err[i]           = (din[i*LW + W] != p);
      end else begin
        dout[i*LW +: LW] = {p, d};
      end
    end
    return {err, dout};
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
    checks++; if (a_out_err !== '0) begin errors++; $display("FAIL reset_out_err got %b exp 0", a_out_err); end
    checks++; if (a_err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", a_err_cnt); end
    checks++; if (b_err_cnt !== '0) begin errors++; $display("FAIL reset_b_err_cnt got %0d exp 0", b_err_cnt); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_generate();
    a_mode      = 1'b0;
    a_out_ready = 1'b1;
    a_in_data   = {1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hAB, 1'b0, 8'hAA};
    a_in_valid  = 1'b1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL gen_in_ready got %b exp 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL gen_out_valid got %b exp 1", a_out_valid); end
    checks++; if (a_out_data !== {9'h1FF, 9'h100, 9'h0AB, 9'h1AA})
      begin errors++; $display("FAIL gen_out_data got %h exp %h", a_out_data, {9'h1FF, 9'h100, 9'h0AB, 9'h1AA}); end
    checks++; if (a_out_err !== 4'b0000) begin errors++; $display("FAIL gen_out_err got %b exp 0000", a_out_err); end
    checks++; if (a_err_cnt !== 16'd0) begin errors++; $display("FAIL gen_err_cnt got %0d exp 0", a_err_cnt); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL gen_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_check();
    a_mode     = 1'b1;
    a_in_data  = {9'h0FF, 9'h100, 9'h1AB, 9'h1AA};
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== {9'h0FF, 9'h100, 9'h1AB, 9'h1AA})
      begin errors++; $display("FAIL chk_out_data got %h exp %h", a_out_data, {9'h0FF, 9'h100, 9'h1AB, 9'h1AA}); end
    checks++; if (a_out_err !== 4'b1010) begin errors++; $display("FAIL chk_out_err got %b exp 1010", a_out_err); end
    checks++; if (a_err_cnt !== 16'd2) begin errors++; $display("FAIL chk_err_cnt got %0d exp 2", a_err_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [BW-1:0]   d0, d1, d2;
    logic            m0, m1, m2;
    logic [BW+L-1:0] e0, e1, e2;
    d0 = rnd_beat(); d1 = rnd_beat(); d2 = rnd_beat();
    m0 = 1'($urandom_range(0, 1)); m1 = 1'($urandom_range(0, 1)); m2 = 1'($urandom_range(0, 1));
    e0 = model(d0, m0, 1'b1); e1 = model(d1, m1, 1'b1); e2 = model(d2, m2, 1'b1);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1; a_in_data = d0; a_mode = m0;
    tick();
    a_in_data = d1; a_mode = m1;
    tick();
    a_in_data = d2; a_mode = m2;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", a_in_ready); end
    checks++; if (a_out_data !== e0[BW-1:0]) begin errors++; $display("FAIL bp_head0 got %h exp %h", a_out_data, e0[BW-1:0]); end
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_held_in_ready got %b exp 0", a_in_ready); end
    checks++; if ({a_out_err, a_out_data} !== e0) begin errors++; $display("FAIL bp_stable got %h exp %h", {a_out_err, a_out_data}, e0); end
    a_out_ready = 1'b1;
    tick();
    checks++; if ({a_out_err, a_out_data} !== e1) begin errors++; $display("FAIL bp_head1 got %h exp %h", {a_out_err, a_out_data}, e1); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b exp 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid2 got %b exp 1", a_out_valid); end
    checks++; if ({a_out_err, a_out_data} !== e2) begin errors++; $display("FAIL bp_head2 got %h exp %h", {a_out_err, a_out_data}, e2); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_full_rate();
    logic [BW+L-1:0] e;
    a_out_ready = 1'b1;
    a_mode      = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_in_data  = rnd_beat();
      a_in_valid = 1'b1;
      e = model(a_in_data, 1'b0, 1'b1);
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fr_in_ready[%0d] got %b exp 1", k, a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL fr_out_valid[%0d] got %b exp 1", k, a_out_valid); end
      checks++; if ({a_out_err, a_out_data} !== e) begin errors++; $display("FAIL fr_beat[%0d] got %h exp %h", k, {a_out_err, a_out_data}, e); end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fr_end got %b exp 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [BW+L-1:0] q[$];
    logic [BW+L-1:0] e;
    logic            acc, pop;
    int              cnt_m;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_cnt_clr = 1'b1;
    tick();
    tick();
    a_err_cnt_clr = 1'b0;
    cnt_m = 0;
    for (int c = 0; c < 400; c++) begin
      a_in_valid    = ($urandom_range(0, 3) != 0);
      a_out_ready   = ($urandom_range(0, 2) != 0);
      a_mode        = 1'($urandom_range(0, 1));
      a_in_data     = rnd_beat();
      a_err_cnt_clr = ($urandom_range(0, 19) == 0);
      acc = a_in_valid && a_in_ready;
      pop = a_out_valid && a_out_ready;
      if (pop && q.size() != 0) void'(q.pop_front());
      e = model(a_in_data, a_mode, 1'b1);
      if (acc) q.push_back(e);
      if (a_err_cnt_clr) cnt_m = 0;
      else if (acc) begin
        cnt_m = cnt_m + $countones(e[BW+L-1:BW]);
        if (cnt_m > 65535) cnt_m = 65535;
      end
      tick();
      checks++; if (a_out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid[%0d] got %b exp %b", c, a_out_valid, q.size() != 0); end
      checks++; if (a_in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", c, a_in_ready, q.size() < 2); end
      if (q.size() != 0) begin
        checks++; if ({a_out_err, a_out_data} !== q[0]) begin errors++; $display("FAIL rnd_head[%0d] got %h exp %h", c, {a_out_err, a_out_data}, q[0]); end
      end
      checks++; if (a_err_cnt !== 16'(cnt_m)) begin errors++; $display("FAIL rnd_err_cnt[%0d] got %0d exp %0d", c, a_err_cnt, cnt_m); end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_cnt_clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_saturate();
    b_out_ready = 1'b1; b_mode = 1'b1; b_err_cnt_clr = 1'b0;
    b_in_data   = {4{9'h1AA}};
    b_in_valid  = 1'b1;
    tick();
    checks++; if (b_out_err !== 4'b1111) begin errors++; $display("FAIL sat_out_err got %b exp 1111", b_out_err); end
    checks++; if (b_err_cnt !== 3'd4) begin errors++; $display("FAIL sat_cnt1 got %0d exp 4", b_err_cnt); end
    tick();
    checks++; if (b_err_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt2 got %0d exp 7", b_err_cnt); end
    tick();
    checks++; if (b_err_cnt !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", b_err_cnt); end
    b_err_cnt_clr = 1'b1;
    tick();
    checks++; if (b_err_cnt !== 3'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", b_err_cnt); end
    b_err_cnt_clr = 1'b0; b_in_valid = 1'b0;
    tick();
    checks++; if (b_err_cnt !== 3'd0) begin errors++; $display("FAIL sat_after_clr got %0d exp 0", b_err_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [BW+L-1:0] e;
    b_out_ready = 1'b0; b_mode = 1'b1;
    b_in_data   = {4{9'h1AA}};
    b_in_valid  = 1'b1;
    tick();
    b_mode = 1'b0; b_in_data = rnd_beat();
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got %b exp 0", b_in_ready); end
    checks++; if (b_err_cnt !== 3'd4) begin errors++; $display("FAIL rm_cnt_pre got %0d exp 4", b_err_cnt); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got %b exp 0", b_out_valid); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rm_async_ready got %b exp 1", b_in_ready); end
    checks++; if (b_err_cnt !== 3'd0) begin errors++; $display("FAIL rm_async_cnt got %0d exp 0", b_err_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d] got %b exp 0", k, b_out_valid); end
    end
    b_mode = 1'b0;
    b_in_data = rnd_beat();
    b_in_data[LW-1:0] = 9'h1AA;
    e = model(b_in_data, 1'b0, 1'b0);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_out_data[LW-1:0] !== 9'h0AA) begin errors++; $display("FAIL rm_even_lane0 got %h exp 0aa", b_out_data[LW-1:0]); end
    checks++; if ({b_out_err, b_out_data} !== e) begin errors++; $display("FAIL rm_even_beat got %h exp %h", {b_out_err, b_out_data}, e); end
    tick();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rm_end got %b exp 0", b_out_valid); end
  endtask

  initial begin
    rstn = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_err_cnt_clr = 1'b0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_err_cnt_clr = 1'b0;
    test_reset();
    test_generate();
    test_check();
    test_backpressure();
    test_full_rate();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
